// File: rtl/reset_sequencer.sv
// Boot sequencer: holds the core in reset, clears the register file one entry
// per cycle, then releases the core on a debounced start code.
module reset_sequencer #(
  parameter int          HOLD_CYCLES = 16,
  parameter int          NUM_REGS    = 16,
  parameter int          ADDR_W      = 4,
  parameter logic [15:0] START_CODE  = 16'h000F,
  parameter logic [15:0] RESET_CODE  = 16'h0011,
  parameter int          DEBOUNCE    = 4
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [15:0]       input_data,
  output logic              core_reset,
  output logic              rf_clr_we,
  output logic [ADDR_W-1:0] rf_clr_addr,
  output logic [1:0]        state,
  output logic              busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > NUM_REGS) ? HOLD_CYCLES : NUM_REGS;
  localparam int CNT_W0  = $clog2(CNT_MAX + 1);
  localparam int CNT_W   = (CNT_W0 > ADDR_W) ? CNT_W0 : ADDR_W;
  localparam int DB_W    = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(NUM_REGS - 1);
  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_CLEAR = 2'b01,
    S_WAIT  = 2'b10,
    S_RUN   = 2'b11
  } state_t;

  state_t            st, st_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DB_W-1:0]   db_cnt, db_nxt, db_run;
  logic [15:0]       prev_data;
  logic [15:0]       code_sel;
  logic              core_reset_nxt, we_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      st          <= S_HOLD;
      cnt         <= '0;
      db_cnt      <= '0;
      prev_data   <= '0;
      core_reset  <= 1'b1;
      rf_clr_we   <= 1'b0;
      rf_clr_addr <= '0;
      busy        <= 1'b1;
    end else begin
      st          <= st_nxt;
      cnt         <= cnt_nxt;
      db_cnt      <= db_nxt;
      prev_data   <= input_data;
      core_reset  <= core_reset_nxt;
      rf_clr_we   <= we_nxt;
      rf_clr_addr <= addr_nxt;
      busy        <= busy_nxt;
    end
  end

  // db_run counts consecutive cycles the watched code has been present,
  // restarting at 1 when it first appears and saturating at DEBOUNCE.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    db_nxt   = '0;
    code_sel = (st == S_RUN) ? RESET_CODE : START_CODE;
    if (input_data != code_sel)
      db_run = '0;
    else if (input_data != prev_data)
      db_run = DB_W'(1);
    else if (db_cnt == DB_MAX)
      db_run = db_cnt;
    else
      db_run = db_cnt + DB_W'(1);

    case (st)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          st_nxt  = S_CLEAR;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_CLEAR: begin
        if (cnt == CLR_LAST) begin
          st_nxt  = S_WAIT;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (db_run == DB_MAX) st_nxt = S_RUN;
        else                  db_nxt = db_run;
      end
      S_RUN: begin
        if (db_run == DB_MAX) begin
          st_nxt  = S_HOLD;
          cnt_nxt = '0;
        end else begin
          db_nxt = db_run;
        end
      end
      default: begin
        st_nxt  = S_HOLD;
        cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come out of registers.
  always_comb begin
    core_reset_nxt = (st_nxt != S_RUN);
    busy_nxt       = (st_nxt != S_RUN);
    we_nxt         = (st_nxt == S_CLEAR);
    addr_nxt       = we_nxt ? cnt_nxt[ADDR_W-1:0] : '0;
  end

  assign state = st;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal
// HOLD_CYCLES=1/NUM_REGS=1/DEBOUNCE=1 instance sharing the same inputs.
module tb_reset_sequencer;

  logic        clk;
  logic        reset_in;
  logic [15:0] input_data;

  logic        core_reset, rf_clr_we, busy;
  logic [3:0]  rf_clr_addr;
  logic [1:0]  state;

  logic        s_core_reset, s_rf_clr_we, s_busy;
  logic [3:0]  s_rf_clr_addr;
  logic [1:0]  s_state;

  int tests_run    = 0;
  int tests_failed = 0;

  reset_sequencer dut (
    .clk(clk), .reset_in(reset_in), .input_data(input_data),
    .core_reset(core_reset), .rf_clr_we(rf_clr_we), .rf_clr_addr(rf_clr_addr),
    .state(state), .busy(busy)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .NUM_REGS(1), .ADDR_W(4), .DEBOUNCE(1)) dut_s (
    .clk(clk), .reset_in(reset_in), .input_data(input_data),
    .core_reset(s_core_reset), .rf_clr_we(s_rf_clr_we), .rf_clr_addr(s_rf_clr_addr),
    .state(s_state), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] din);
    input_data = din;
    reset_in   = 1'b0;
    tick();
    tick();
    reset_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_in   = 1'b1;
    input_data = 16'h0000;
    #2 reset_in = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({state, core_reset, rf_clr_we, rf_clr_addr, busy} !== {2'b00, 1'b1, 1'b0, 4'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_values: got st=%b cr=%b we=%b addr=%h busy=%b, expected st=00 cr=1 we=0 addr=0 busy=1",
               state, core_reset, rf_clr_we, rf_clr_addr, busy);
    end
    tests_run++;
    if ({s_state, s_core_reset, s_rf_clr_we, s_busy} !== {2'b00, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_values_small: got st=%b cr=%b we=%b busy=%b, expected st=00 cr=1 we=0 busy=1",
               s_state, s_core_reset, s_rf_clr_we, s_busy);
    end
    reset_in = 1'b1;
  endtask

  // Release with 000F held: HOLD edges 1-16, CLEAR 17-32, WAIT 33-36, RUN at 37.
  task automatic test_boot();
    logic [1:0] exp_st;
    logic       exp_we, exp_cr;
    logic [3:0] exp_addr;
    do_reset(16'h000F);
    for (int e = 1; e <= 37; e++) begin
      tick();
      exp_st   = (e <= 16) ? 2'b00 : (e <= 32) ? 2'b01 : (e <= 36) ? 2'b10 : 2'b11;
      exp_we   = (exp_st == 2'b01);
      exp_addr = exp_we ? 4'(e - 17) : 4'h0;
      exp_cr   = (e < 37);
      tests_run++;
      if ({state, core_reset, rf_clr_we, rf_clr_addr, busy} !== {exp_st, exp_cr, exp_we, exp_addr, exp_cr}) begin
        tests_failed++;
        $display("FAIL boot_edge_%0d: got st=%b cr=%b we=%b addr=%h busy=%b, expected st=%b cr=%b we=%b addr=%h busy=%b",
                 e, state, core_reset, rf_clr_we, rf_clr_addr, busy, exp_st, exp_cr, exp_we, exp_addr, exp_cr);
      end
    end
  endtask

  task automatic test_wait_toggle();
    do_reset(16'h0000);
    repeat (33) tick();
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("FAIL toggle_enter_wait: got st=%b expected 10", state);
    end
    for (int i = 0; i < 20; i++) begin
      input_data = (i % 4 < 2) ? 16'h000F : 16'h0000;
      tick();
      tests_run++;
      if ({state, core_reset} !== {2'b10, 1'b1}) begin
        tests_failed++;
        $display("FAIL toggle_stay_wait_%0d: got st=%b cr=%b expected st=10 cr=1", i, state, core_reset);
      end
    end
    input_data = 16'h000F;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if ({state, core_reset, busy} !== ((i < 4) ? {2'b10, 1'b1, 1'b1} : {2'b11, 1'b0, 1'b0})) begin
        tests_failed++;
        $display("FAIL toggle_hold_start_%0d: got st=%b cr=%b busy=%b", i, state, core_reset, busy);
      end
    end
  endtask

  // Entered from RUN (left there by test_wait_toggle).
  task automatic test_soft_reset();
    input_data = 16'h0011;
    repeat (3) tick();
    input_data = 16'h0000;
    tick();
    tick();
    tests_run++;
    if ({state, core_reset} !== {2'b11, 1'b0}) begin
      tests_failed++;
      $display("FAIL soft_short_pulse: got st=%b cr=%b expected st=11 cr=0", state, core_reset);
    end
    input_data = 16'h0011;
    repeat (3) tick();
    tests_run++;
    if (state !== 2'b11) begin
      tests_failed++;
      $display("FAIL soft_three_cycles: got st=%b expected 11", state);
    end
    tick();
    tests_run++;
    if ({state, core_reset, busy, rf_clr_we} !== {2'b00, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL soft_to_hold: got st=%b cr=%b busy=%b we=%b expected st=00 cr=1 busy=1 we=0",
               state, core_reset, busy, rf_clr_we);
    end
    input_data = 16'h000F;
    for (int e = 1; e <= 37; e++) begin
      tick();
      if (e == 16 || e == 17 || e == 32 || e == 36 || e == 37) begin
        tests_run++;
        if ((e == 16 && {state, rf_clr_we} !== {2'b00, 1'b0}) ||
            (e == 17 && {state, rf_clr_we, rf_clr_addr} !== {2'b01, 1'b1, 4'h0}) ||
            (e == 32 && {state, rf_clr_we, rf_clr_addr} !== {2'b01, 1'b1, 4'hF}) ||
            (e == 36 && {state, core_reset} !== {2'b10, 1'b1}) ||
            (e == 37 && {state, core_reset} !== {2'b11, 1'b0})) begin
          tests_failed++;
          $display("FAIL soft_repeat_edge_%0d: got st=%b cr=%b we=%b addr=%h", e, state, core_reset, rf_clr_we, rf_clr_addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset(16'h000F);
    repeat (24) tick();
    tests_run++;
    if ({state, rf_clr_we, rf_clr_addr} !== {2'b01, 1'b1, 4'h7}) begin
      tests_failed++;
      $display("FAIL midclear_at_addr7: got st=%b we=%b addr=%h expected st=01 we=1 addr=7", state, rf_clr_we, rf_clr_addr);
    end
    #4 reset_in = 1'b0;
    #1;
    tests_run++;
    if ({state, core_reset, rf_clr_we, rf_clr_addr, busy} !== {2'b00, 1'b1, 1'b0, 4'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL midclear_async_reset: got st=%b cr=%b we=%b addr=%h busy=%b expected st=00 cr=1 we=0 addr=0 busy=1",
               state, core_reset, rf_clr_we, rf_clr_addr, busy);
    end
    tick();
    reset_in = 1'b1;
    repeat (16) tick();
    tests_run++;
    if ({state, rf_clr_we} !== {2'b00, 1'b0}) begin
      tests_failed++;
      $display("FAIL midclear_rehold: got st=%b we=%b expected st=00 we=0", state, rf_clr_we);
    end
    tick();
    tests_run++;
    if ({state, rf_clr_we, rf_clr_addr} !== {2'b01, 1'b1, 4'h0}) begin
      tests_failed++;
      $display("FAIL midclear_restart_addr0: got st=%b we=%b addr=%h expected st=01 we=1 addr=0", state, rf_clr_we, rf_clr_addr);
    end
    repeat (15) tick();
    tests_run++;
    if ({state, rf_clr_we, rf_clr_addr} !== {2'b01, 1'b1, 4'hF}) begin
      tests_failed++;
      $display("FAIL midclear_last_addr: got st=%b we=%b addr=%h expected st=01 we=1 addr=F", state, rf_clr_we, rf_clr_addr);
    end
    tick();
    tests_run++;
    if ({state, rf_clr_we, rf_clr_addr} !== {2'b10, 1'b0, 4'h0}) begin
      tests_failed++;
      $display("FAIL midclear_to_wait: got st=%b we=%b addr=%h expected st=10 we=0 addr=0", state, rf_clr_we, rf_clr_addr);
    end
  endtask

  task automatic test_wait_ignores_reset_code();
    do_reset(16'h0000);
    repeat (33) tick();
    input_data = 16'h0011;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if ({state, core_reset, busy} !== {2'b10, 1'b1, 1'b1}) begin
        tests_failed++;
        $display("FAIL wait_reset_code_%0d: got st=%b cr=%b busy=%b expected st=10 cr=1 busy=1", i, state, core_reset, busy);
      end
    end
  endtask

  // Minimal instance: HOLD edge 1, CLEAR edge 2, WAIT edge 3, RUN edge 4.
  task automatic test_small();
    logic [1:0] exp_st;
    do_reset(16'h000F);
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_st = (e == 1) ? 2'b00 : (e == 2) ? 2'b01 : (e == 3) ? 2'b10 : 2'b11;
      tests_run++;
      if ({s_state, s_core_reset, s_rf_clr_we, s_rf_clr_addr} !== {exp_st, (e < 4), (e == 2), 4'h0}) begin
        tests_failed++;
        $display("FAIL small_edge_%0d: got st=%b cr=%b we=%b addr=%h expected st=%b cr=%b we=%b addr=0",
                 e, s_state, s_core_reset, s_rf_clr_we, s_rf_clr_addr, exp_st, (e < 4), (e == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_wait_toggle();
    test_soft_reset();
    test_reset_mid_clear();
    test_wait_ignores_reset_code();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
